// File: rtl/sat_acc_pkg.sv
// Shared types and saturation limits for the streaming saturating accumulator.
package sat_acc_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    // Largest positive value of a signed two's-complement word of the given width.
    function automatic logic [63:0] sat_max(input int unsigned width);
        sat_max = (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative value of a signed two's-complement word of the given width.
    function automatic logic [63:0] sat_min(input int unsigned width);
        sat_min = 64'd0 - (64'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/sat_step_add.sv
// Combinational signed add with clamp to the representable range and an overflow flag.
module sat_step_add
    import sat_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum_c,
    output logic             ovf_c
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

    logic [WIDTH-1:0] raw;

    // Overflow only when both operands share a sign that the wrapped sum loses.
    always_comb begin
        raw   = a + b;
        ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        sum_c = raw;
        if (ovf_c) begin
            sum_c = a[WIDTH-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/sat_accumulator_stream.sv
// Sums COUNT signed samples per frame with per-step saturation; emits one clamped sum per frame.
// Define SAT_ACCUMULATOR_STREAM_OVERLAP_EN to accept a new sample in the output-handshake cycle.
module sat_accumulator_stream
    import sat_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    localparam int unsigned     CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             frame_sat, frame_sat_next;
    logic             out_valid_next;
    logic [WIDTH-1:0] out_data_next;
    logic             out_sat_next;
    logic [WIDTH-1:0] step_sum;
    logic             step_ovf;
    logic             accept;

    sat_step_add #(.WIDTH(WIDTH)) u_step (
        .a    (acc),
        .b    (in_data),
        .sum_c(step_sum),
        .ovf_c(step_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            frame_sat <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            frame_sat <= frame_sat_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            out_sat   <= out_sat_next;
        end
    end

    // acc/cnt/frame_sat are already zero in OUTPUT, so an overlapped sample reuses the ACCUM path.
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        cnt_next       = cnt;
        frame_sat_next = frame_sat;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        out_sat_next   = out_sat;

`ifdef SAT_ACCUMULATOR_STREAM_OVERLAP_EN
        in_ready = (state == ACCUM) || ((state == OUTPUT) && out_ready);
`else
        in_ready = (state == ACCUM);
`endif
        accept = in_valid && in_ready;

        if ((state == OUTPUT) && out_ready) begin
            out_valid_next = 1'b0;
            state_next     = ACCUM;
        end

        if (accept) begin
            if (cnt == LAST) begin
                out_data_next  = step_sum;
                out_sat_next   = frame_sat | step_ovf;
                out_valid_next = 1'b1;
                acc_next       = '0;
                cnt_next       = '0;
                frame_sat_next = 1'b0;
                state_next     = OUTPUT;
            end else begin
                acc_next       = step_sum;
                frame_sat_next = frame_sat | step_ovf;
                cnt_next       = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sat_accumulator_stream.sv
// Directed bench for sat_accumulator_stream at WIDTH=4, COUNT=4.
module tb_sat_accumulator_stream;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned COUNT = 4;
`ifdef SAT_ACCUMULATOR_STREAM_OVERLAP_EN
    localparam int PERIOD = 4;
    localparam int FRAMES = 10;
`else
    localparam int PERIOD = 5;
    localparam int FRAMES = 8;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;

    int vectors = 0;
    int errors  = 0;

    sat_accumulator_stream #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives four samples on consecutive cycles; returns just after the 4th accepting edge.
    task automatic frame(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        logic [3:0] s [4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain(input string tag);
        @(posedge clk); #1;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int nvalid;
        int last;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_sat",   32'(out_sat),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1,2,-1,3 -> 5, no clamp
        frame(4'd1, 4'd2, 4'hF, 4'd3);
        check("f1_valid", 32'(out_valid), 32'd1);
        check("f1_data",  32'(out_data),  32'd5);
        check("f1_sat",   32'(out_sat),   32'd0);
        drain("f1");

        // 4,7,-2,1 -> 4,7(clamp),5,6
        frame(4'd4, 4'd7, 4'hE, 4'd1);
        check("f2_valid", 32'(out_valid), 32'd1);
        check("f2_data",  32'(out_data),  32'd6);
        check("f2_sat",   32'(out_sat),   32'd1);
        drain("f2");

        // -4,-7,-8,7 -> -4,-8(clamp),-8(clamp),-1
        frame(4'hC, 4'h9, 4'h8, 4'd7);
        check("f3_valid", 32'(out_valid), 32'd1);
        check("f3_data",  32'(out_data),  32'hF);
        check("f3_sat",   32'(out_sat),   32'd1);
        drain("f3");

        // Backpressure: result held, no sample consumed while stalled
        out_ready = 1'b0;
        frame(4'd1, 4'd1, 4'd1, 4'd1);
        in_valid = 1'b1;
        in_data  = 4'd3;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_data",     32'(out_data),  32'd4);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid",    32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready),  32'd1);
        frame(4'd1, 4'd1, 4'd1, 4'd1);
        check("bp_next_data", 32'(out_data), 32'd4);
        check("bp_next_sat",  32'(out_sat),  32'd0);
        drain("bp_next");

        // Stalled 2,2,2,2 -> 2,4,6,7(clamp)
        out_ready = 1'b0;
        frame(4'd2, 4'd2, 4'd2, 4'd2);
        check("f4_data", 32'(out_data), 32'd7);
        check("f4_sat",  32'(out_sat),  32'd1);
        out_ready = 1'b1;
        drain("f4");

        // Reset mid-frame after 5,5 (which clamps)
        in_valid = 1'b1;
        in_data  = 4'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    32'(out_valid), 32'd0);
        check("mid_rst_data",     32'(out_data),  32'd0);
        check("mid_rst_sat",      32'(out_sat),   32'd0);
        check("mid_rst_in_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame(4'd1, 4'd1, 4'd1, 4'd1);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data",  32'(out_data),  32'd4);
        check("post_rst_sat",   32'(out_sat),   32'd0);
        drain("post_rst");

        // Throughput under continuous valid/ready
        nvalid   = 0;
        last     = 0;
        in_valid = 1'b1;
        in_data  = 4'd1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                check("tp_data", 32'(out_data), 32'd4);
                if (last > 0) check("tp_interval", 32'(i - last), 32'(PERIOD));
                last = i;
                nvalid++;
            end
        end
        in_valid = 1'b0;
        check("tp_frames", 32'(nvalid), 32'(FRAMES));
        check("tp_first", 32'(last - (FRAMES - 1) * PERIOD), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
